key_filter_multi: RTL and testbench
===================================

// Module: key_filter_multi
// PURPOSE
//   N-channel push-button conditioner; generalises the single-key debouncer in
//   the edge-detection top. Each channel: 2-flop synchroniser, press/release
//   debounce FSM, long-press detect with optional auto-repeat. Emits 1-cycle
//   event pulses plus a level. Feeds mode/threshold control of the video path.
// PARAMETERS
//   KEY_NUM      4          number of independent key channels (>=1)
//   ACTIVE_LOW   1          1: key_in low = pressed; 0: key_in high = pressed
//   DEBOUNCE_CNT 1_000_000  cycles of stable level to accept an edge (>=2; 20 ms @ 50 MHz)
//   LONG_CNT     50_000_000 cycles held after key_press before first key_long (>=1)
//   REPEAT_CNT   0          0: one key_long per hold; >0: re-pulse key_long every REPEAT_CNT cycles
// PORTS
//   clk          in   1        system clock
//   rst_n        in   1        asynchronous active-low reset
//   key_in       in   KEY_NUM  raw asynchronous key pins, bit i = channel i
//   key_press    out  KEY_NUM  1-cycle pulse: debounced press accepted
//   key_release  out  KEY_NUM  1-cycle pulse: debounced release accepted
//   key_long     out  KEY_NUM  1-cycle pulse: long-press / auto-repeat tick
//   key_state    out  KEY_NUM  debounced level, 1 = pressed
// BEHAVIOUR
//   - Reset: all outputs 0; FSMs IDLE; counters 0; sync flops at released level.
//   - Sync: key_in -> 2 flops -> polarity-normalised p (1 = pressed).
//   - Per channel, independent FSM + filter counter fcnt + hold counter hcnt
//     ($clog2 of the largest count each must reach):
//     IDLE:  p=1 -> PRESS_F, fcnt=0.
//     PRESS_F: p=0 -> IDLE; else fcnt++; at fcnt==DEBOUNCE_CNT-1 -> DOWN,
//       key_press=1 that cycle, key_state<=1, hcnt=0.
//     DOWN: hcnt++ each cycle; at hcnt==LONG_CNT-1 key_long=1; then if
//       REPEAT_CNT>0 key_long=1 every REPEAT_CNT cycles (hcnt reloads to
//       LONG_CNT-REPEAT_CNT); if REPEAT_CNT==0 hcnt saturates, no more pulses.
//       p=0 -> REL_F, fcnt=0.
//     REL_F: hcnt frozen; p=1 -> DOWN (bounce ignored, hcnt resumes, no pulse);
//       at fcnt==DEBOUNCE_CNT-1 -> IDLE, key_release=1, key_state<=0.
//   - Latency: clean edge on key_in -> key_press/key_release exactly
//     2+DEBOUNCE_CNT cycles later. First key_long LONG_CNT cycles after key_press.
//   - Any bounce inside a filter window restarts from that state's entry rule;
//     glitches shorter than DEBOUNCE_CNT never produce pulses.
//   - Pulses are registered, never more than one cycle wide; key_press and
//     key_release never coincide on one channel; channels may pulse together.
//   - Key held through reset release: treated as fresh press (key_press after
//     2+DEBOUNCE_CNT). Reset mid-hold/mid-filter: no pending pulse survives.
// TESTING (KEY_NUM=4, ACTIVE_LOW=1, DEBOUNCE_CNT=100, LONG_CNT=500, REPEAT_CNT=200)
//   1 key_in[0] 1->0 clean at cycle T -> key_press[0] one pulse at T+102,
//     key_state[0]=1; release at T+300 -> key_release[0] at T+402, state 0.
//   2 key_in[1] toggles every 30 cycles for 1000 cycles, then returns high
//     -> no pulses on any output, key_state[1] stays 0.
//   3 key_in[2] held low 1500 cycles from T -> key_press at T+102, key_long
//     at T+602, T+802, T+1002, T+1202, T+1402; key_release at T+1602.
//   4 While ch3 is DOWN, 50-cycle high glitch -> no key_release, key_state[3]
//     stays 1, long tick delayed by exactly 50 cycles (hcnt frozen).
//   5 key_in[0] and key_in[3] fall same cycle -> key_press[0] and [3]
//     pulse same cycle; ch1/ch2 unaffected.
//   6 rst_n low for 3 cycles at T+50 of a press filter -> all outputs 0,
//     key still held -> key_press at (rst release)+102.

Source files
------------

// File: rtl/key_filter_multi.sv
// key_filter_multi
//   N-channel push-button conditioner. Every channel has its own 2-flop
//   synchroniser, a press/release debounce FSM, and a long-press detector
//   with optional auto-repeat. All event outputs are registered 1-cycle
//   pulses. key_state is the debounced level.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_in       raw asynchronous key pins, bit i = channel i
//   key_press    1-cycle pulse, debounced press accepted
//   key_release  1-cycle pulse, debounced release accepted
//   key_long     1-cycle pulse, long-press / auto-repeat tick
//   key_state    debounced level, 1 = pressed
//
// State table (per channel)
//   IDLE    | key released, waiting for a pressed sample
//   PRESS_F | press filter: p must stay 1 for DEBOUNCE_CNT cycles
//   DOWN    | key pressed; hold counter advances toward long-press ticks
//   REL_F   | release filter: hold counter frozen; p=1 returns to DOWN
//
// REPEAT_CNT is assumed to be no larger than LONG_CNT, because the repeat
// period is produced by reloading the hold counter to LONG_CNT-REPEAT_CNT.
module key_filter_multi #(
  parameter int KEY_NUM      = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CNT = 1_000_000,
  parameter int LONG_CNT     = 50_000_000,
  parameter int REPEAT_CNT   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_state
);

  localparam int FW = $clog2(DEBOUNCE_CNT);
  localparam int HW = $clog2(LONG_CNT + 1);

  localparam logic [FW-1:0] F_LAST   = FW'(DEBOUNCE_CNT - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(LONG_CNT - 1);
  // Parking value once the single long tick has fired (no-repeat mode).
  localparam logic [HW-1:0] H_SAT    = HW'(LONG_CNT);
  localparam logic [HW-1:0] H_RELOAD = HW'(LONG_CNT - REPEAT_CNT);

  localparam logic [KEY_NUM-1:0] REL_LVL = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS_F = 2'd1,
    DOWN    = 2'd2,
    REL_F   = 2'd3
  } state_t;

  logic [KEY_NUM-1:0] sync1;
  logic [KEY_NUM-1:0] sync2;
  logic [KEY_NUM-1:0] p;

  // Sync flops reset to the released level so a key held through reset is
  // seen as a fresh press after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= REL_LVL;
      sync2 <= REL_LVL;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign p = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    state_t          st;
    state_t          st_nx;
    logic [FW-1:0]   fcnt;
    logic [FW-1:0]   fcnt_nx;
    logic [HW-1:0]   hcnt;
    logic [HW-1:0]   hcnt_nx;
    logic            press_q, press_nx;
    logic            rel_q, rel_nx;
    logic            long_q, long_nx;
    logic            lvl_q, lvl_nx;
    logic            adv;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st      <= IDLE;
        fcnt    <= '0;
        hcnt    <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        lvl_q   <= 1'b0;
      end else begin
        st      <= st_nx;
        fcnt    <= fcnt_nx;
        hcnt    <= hcnt_nx;
        press_q <= press_nx;
        rel_q   <= rel_nx;
        long_q  <= long_nx;
        lvl_q   <= lvl_nx;
      end
    end

    always_comb begin
      st_nx    = st;
      fcnt_nx  = fcnt;
      hcnt_nx  = hcnt;
      press_nx = 1'b0;
      rel_nx   = 1'b0;
      long_nx  = 1'b0;
      lvl_nx   = lvl_q;
      adv      = 1'b0;

      case (st)
        IDLE: begin
          if (p[i]) begin
            st_nx   = PRESS_F;
            fcnt_nx = '0;
          end
        end
        PRESS_F: begin
          if (!p[i]) begin
            st_nx = IDLE;
          end else if (fcnt == F_LAST) begin
            st_nx    = DOWN;
            press_nx = 1'b1;
            lvl_nx   = 1'b1;
            hcnt_nx  = '0;
          end else begin
            fcnt_nx = fcnt + 1'b1;
          end
        end
        DOWN: begin
          if (!p[i]) begin
            st_nx   = REL_F;
            fcnt_nx = '0;
          end else begin
            adv = 1'b1;
          end
        end
        REL_F: begin
          // A bounce back to pressed resumes the hold count on that same
          // cycle, so a glitch of n cycles delays the next tick by exactly n.
          if (p[i]) begin
            st_nx = DOWN;
            adv   = 1'b1;
          end else if (fcnt == F_LAST) begin
            st_nx  = IDLE;
            rel_nx = 1'b1;
            lvl_nx = 1'b0;
          end else begin
            fcnt_nx = fcnt + 1'b1;
          end
        end
        default: begin
          st_nx = IDLE;
        end
      endcase

      if (adv) begin
        if (hcnt == H_LAST) begin
          long_nx = 1'b1;
          hcnt_nx = (REPEAT_CNT > 0) ? H_RELOAD : H_SAT;
        end else if (hcnt != H_SAT) begin
          hcnt_nx = hcnt + 1'b1;
        end
      end
    end

    assign key_press[i]   = press_q;
    assign key_release[i] = rel_q;
    assign key_long[i]    = long_q;
    assign key_state[i]   = lvl_q;
  end

endmodule

// File: tb/tb_key_filter_multi.sv
// Testbench for key_filter_multi (KEY_NUM=4, ACTIVE_LOW=1, DEBOUNCE_CNT=100,
// LONG_CNT=500, REPEAT_CNT=200). Stimulus pushes expected pulse events
// (cycle, kind, channel) into a queue; a monitor compares every cycle in
// which the DUT pulses or a pulse is expected.
module tb_key_filter_multi;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] key_in;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic [N-1:0] key_long;
  logic [N-1:0] key_state;

  key_filter_multi #(
    .KEY_NUM     (N),
    .ACTIVE_LOW  (1),
    .DEBOUNCE_CNT(100),
    .LONG_CNT    (500),
    .REPEAT_CNT  (200)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_state  (key_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc == number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int at;
    int kind;  // 0 press, 1 release, 2 long
    int ch;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic push(input int at, input int kind, input int ch);
    ev_t e;
    e.at = at; e.kind = kind; e.ch = ch;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [3*N-1:0] act;
    logic [3*N-1:0] expv;
    if (rst_n) begin
      act  = {key_long, key_release, key_press};
      expv = '0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].at == cyc) begin
          expv[exp_q[i].kind*N + exp_q[i].ch] = 1'b1;
          exp_q.delete(i);
        end else if (exp_q[i].at < cyc) begin
          total++;
          bad++;
          $display("FAIL stale_event at=%0d kind=%0d ch=%0d", exp_q[i].at, exp_q[i].kind, exp_q[i].ch);
          exp_q.delete(i);
        end
      end
      if (act != '0 || expv != '0) begin
        total++;
        if (act !== expv) begin
          bad++;
          $display("FAIL pulses cyc=%0d actual(long,rel,press)=%h required=%h", cyc, act, expv);
        end
      end
    end
  end

  initial begin
    int t;
    int r;
    key_in = '1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {16'd0, key_press, key_release, key_long, key_state}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 1: clean press / release on ch0
    key_in[0] = 1'b0; t = cyc + 1;
    push(t + 102, 0, 0); push(t + 402, 1, 0);
    wait_until(t + 101); chk("t1_state_before", key_state[0], 0);
    wait_until(t + 102); chk("t1_state_after", key_state[0], 1);
    wait_until(t + 299); key_in[0] = 1'b1;
    wait_until(t + 401); chk("t1_state_prerel", key_state[0], 1);
    wait_until(t + 402); chk("t1_state_rel", key_state[0], 0);
    wait_until(t + 500);

    // 2: ch1 bounces every 30 cycles -> nothing
    for (int i = 0; i < 34; i++) begin
      key_in[1] = ~key_in[1];
      repeat (30) @(negedge clk);
    end
    key_in[1] = 1'b1;
    repeat (200) @(negedge clk);
    chk("t2_state", key_state, 0);

    // 3: ch2 long hold with auto-repeat
    key_in[2] = 1'b0; t = cyc + 1;
    push(t + 102, 0, 2);
    for (int k = 0; k < 5; k++) push(t + 602 + 200 * k, 2, 2);
    push(t + 1602, 1, 2);
    wait_until(t + 1499); key_in[2] = 1'b1;
    wait_until(t + 1700); chk("t3_state", key_state, 0);

    // 4: ch3 glitch while DOWN delays long tick by 50
    key_in[3] = 1'b0; t = cyc + 1;
    push(t + 102, 0, 3); push(t + 652, 2, 3); push(t + 852, 2, 3); push(t + 1002, 1, 3);
    wait_until(t + 199); key_in[3] = 1'b1;
    wait_until(t + 240); chk("t4_state_glitch", key_state[3], 1);
    wait_until(t + 249); key_in[3] = 1'b0;
    wait_until(t + 899); key_in[3] = 1'b1;
    wait_until(t + 1100); chk("t4_state_end", key_state, 0);

    // 5: ch0 and ch3 together
    key_in[0] = 1'b0; key_in[3] = 1'b0; t = cyc + 1;
    push(t + 102, 0, 0); push(t + 102, 0, 3);
    push(t + 302, 1, 0); push(t + 302, 1, 3);
    wait_until(t + 150); chk("t5_state_both", key_state, 4'b1001);
    wait_until(t + 199); key_in[0] = 1'b1; key_in[3] = 1'b1;
    wait_until(t + 400); chk("t5_state_end", key_state, 0);

    // 6: reset in the middle of a press filter, key stays held
    key_in[1] = 1'b0; t = cyc + 1;
    push(t + 102, 0, 1);
    wait_until(t + 49);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_reset_outputs", {16'd0, key_press, key_release, key_long, key_state}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; r = cyc + 1;
    push(r + 102, 0, 1);
    wait_until(r + 101); chk("t6_state_before", key_state[1], 0);
    wait_until(r + 102); chk("t6_state_after", key_state[1], 1);
    wait_until(r + 149); key_in[1] = 1'b1;
    push(r + 252, 1, 1);
    wait_until(r + 400);
    chk("pending_events", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
